mem_arbiter_rr: RTL and testbench

- N-port memory arbiter between L1 caches (I-cache, D-cache, prefetcher, ...) and the L2 cache / cacheline adaptor.
- Generalises the fixed two-port I/D arbiter:
  - parametrised port count and line width;
  - selectable round-robin or fixed-priority arbitration;
  - request snapshotting at grant;
  - per-port saturating grant counters for performance analysis.
- Exactly one downstream transaction is outstanding at a time.

---
 rtl/mem_arbiter_rr.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter between L1 requesters and the L2 / cacheline adaptor.
// One downstream transaction at a time, round-robin or fixed-priority selection.
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int RR_MODE   = 1,
    parameter int CNT_W     = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        up_read,
    input  logic [NUM_PORTS-1:0]        up_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] up_address,
    input  logic [NUM_PORTS*LINE_W-1:0] up_wdata,
    output logic [LINE_W-1:0]           up_rdata,
    output logic [NUM_PORTS-1:0]        up_resp,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic [LINE_W-1:0]           mem_rdata,
    input  logic                        mem_resp,
    output logic [NUM_PORTS*CNT_W-1:0]  grant_count,
    output logic                        busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    arbState_t              r_state;
    logic [IDX_W-1:0]       r_lastGrant;
    logic [IDX_W-1:0]       r_grantIdx;
    logic                   r_memRead;
    logic                   r_memWrite;
    logic [ADDR_W-1:0]      r_addr;
    logic [LINE_W-1:0]      r_wdata;
    logic [LINE_W-1:0]      r_rdata;
    logic                   r_busy;
    logic [CNT_W-1:0]       r_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0]   w_req;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_found;
    logic                   w_respFire;
    logic [NUM_PORTS-1:0]   w_resp;
    int                     w_idx;

    assign w_req = up_read | up_write;

    // Scan starts just after the last winner in round-robin mode, at port 0 otherwise.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                w_idx = (int'(r_lastGrant) + k) % NUM_PORTS;
            end else begin
                w_idx = k - 1;
            end
            if (!w_found && w_req[IDX_W'(w_idx)]) begin
                w_winner = IDX_W'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    assign w_respFire = (r_state == BUSY) && mem_resp && reset_n;

    always_comb begin
        w_resp = '0;
        if (w_respFire) begin
            w_resp[r_grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_lastGrant <= IDX_W'(NUM_PORTS - 1);
            r_grantIdx  <= '0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grantIdx <= w_winner;
                        r_memWrite <= up_write[w_winner];
                        r_memRead  <= ~up_write[w_winner];
                        r_addr     <= up_address[w_winner*ADDR_W +: ADDR_W];
                        r_wdata    <= up_wdata[w_winner*LINE_W +: LINE_W];
                        r_busy     <= 1'b1;
                        if (r_cnt[w_winner] != '1) begin
                            r_cnt[w_winner] <= r_cnt[w_winner] + CNT_W'(1);
                        end
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        r_memRead   <= 1'b0;
                        r_memWrite  <= 1'b0;
                        r_rdata     <= mem_rdata;
                        r_lastGrant <= r_grantIdx;
                        r_state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Idle turnaround cycle so the granted cache can drop its request.
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign grant_count[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    assign up_resp     = w_resp;
    assign up_rdata    = w_respFire ? mem_rdata : r_rdata;
    assign mem_read    = r_memRead;
    assign mem_write   = r_memWrite;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Drives a round-robin and a fixed-priority arbiter with identical upstream traffic
// and compares both against a transaction-level reference model.
module tb_mem_arbiter_rr;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [3:0]     upRead;
    logic [3:0]     upWrite;
    logic [127:0]   upAddress;
    logic [255:0]   upWdata;
    logic [63:0]    memRdata;
    logic           memResp;

    logic [63:0]    upRdata    [2];
    logic [3:0]     upResp     [2];
    logic           memRead    [2];
    logic           memWrite   [2];
    logic [31:0]    memAddress [2];
    logic [63:0]    memWdata   [2];
    logic           busyOut    [2];
    logic [7:0]     rrCount;
    logic [31:0]    fpCount;

    int             checkCount = 0;
    int             failCount  = 0;
    int             mLast;
    int             mCnt [2][4];
    int             cntMax [2] = '{3, 255};
    logic [63:0]    mRdata;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.NUM_PORTS(4), .LINE_W(64), .ADDR_W(32), .RR_MODE(1), .CNT_W(2)) dutRr (
        .clk(clk), .reset_n(reset_n),
        .up_read(upRead), .up_write(upWrite), .up_address(upAddress), .up_wdata(upWdata),
        .up_rdata(upRdata[0]), .up_resp(upResp[0]),
        .mem_read(memRead[0]), .mem_write(memWrite[0]), .mem_address(memAddress[0]),
        .mem_wdata(memWdata[0]), .mem_rdata(memRdata), .mem_resp(memResp),
        .grant_count(rrCount), .busy(busyOut[0])
    );

    mem_arbiter_rr #(.NUM_PORTS(4), .LINE_W(64), .ADDR_W(32), .RR_MODE(0), .CNT_W(8)) dutFp (
        .clk(clk), .reset_n(reset_n),
        .up_read(upRead), .up_write(upWrite), .up_address(upAddress), .up_wdata(upWdata),
        .up_rdata(upRdata[1]), .up_resp(upResp[1]),
        .mem_read(memRead[1]), .mem_write(memWrite[1]), .mem_address(memAddress[1]),
        .mem_wdata(memWdata[1]), .mem_rdata(memRdata), .mem_resp(memResp),
        .grant_count(fpCount), .busy(busyOut[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int getCnt(input int d, input int p);
        if (d == 0) return int'(rrCount[p*2 +: 2]);
        return int'(fpCount[p*8 +: 8]);
    endfunction

    // Round-robin: the nearest requester after the previous winner; fixed: lowest index.
    function automatic int expWinner(input int d, input logic [3:0] req);
        int order [$];
        if (d == 1) begin
            for (int p = 0; p < 4; p++) if (req[p]) return p;
            return -1;
        end
        for (int p = mLast + 1; p < 4; p++) order.push_back(p);
        for (int p = 0; p <= mLast; p++) order.push_back(p);
        foreach (order[i]) if (req[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic randomizeData();
        for (int p = 0; p < 4; p++) begin
            upAddress[p*32 +: 32] = $urandom;
            upWdata[p*64 +: 64]   = {$urandom, $urandom};
        end
    endtask

    task automatic checkCounts(input string tag);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 4; p++)
                checkOutput(tag, 64'(getCnt(d, p)), 64'(mCnt[d][p]));
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        memResp = 1'b0;
        upRead  = '0;
        upWrite = '0;
        tick();
        tick();
        reset_n = 1'b1;
        mLast   = 3;
        mRdata  = '0;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 4; p++) mCnt[d][p] = 0;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rstBusy", 64'(busyOut[d]), 64'd0);
            checkOutput("rstMemRead", 64'(memRead[d]), 64'd0);
            checkOutput("rstMemWrite", 64'(memWrite[d]), 64'd0);
            checkOutput("rstMemAddr", 64'(memAddress[d]), 64'd0);
            checkOutput("rstMemWdata", memWdata[d], 64'd0);
            checkOutput("rstUpRdata", upRdata[d], 64'd0);
            checkOutput("rstUpResp", 64'(upResp[d]), 64'd0);
        end
        checkCounts("rstCount");
    endtask

    // One full transaction using the upstream requests already set up by the caller.
    task automatic applyStimulus(input int lat, input logic [63:0] rdata);
        logic [3:0]  req;
        int          w [2];
        logic        expWr [2];
        logic [31:0] expAddr [2];
        logic [63:0] expWd [2];
        req = upRead | upWrite;
        for (int d = 0; d < 2; d++) begin
            w[d]       = expWinner(d, req);
            expWr[d]   = upWrite[w[d]];
            expAddr[d] = upAddress[w[d]*32 +: 32];
            expWd[d]   = upWdata[w[d]*64 +: 64];
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("grantRead", 64'(memRead[d]), 64'(!expWr[d]));
            checkOutput("grantWrite", 64'(memWrite[d]), 64'(expWr[d]));
            checkOutput("grantAddr", 64'(memAddress[d]), 64'(expAddr[d]));
            checkOutput("grantWdata", memWdata[d], expWd[d]);
            checkOutput("grantBusy", 64'(busyOut[d]), 64'd1);
            checkOutput("grantNoResp", 64'(upResp[d]), 64'd0);
        end
        upRead  = 4'($urandom) | 4'b0001;
        upWrite = 4'($urandom);
        randomizeData();
        repeat (lat) tick();
        memRdata = rdata;
        memResp  = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("snapAddr", 64'(memAddress[d]), 64'(expAddr[d]));
            checkOutput("snapWrite", 64'(memWrite[d]), 64'(expWr[d]));
            checkOutput("respOneHot", 64'(upResp[d]), 64'(4'b0001 << w[d]));
            checkOutput("respRdata", upRdata[d], rdata);
        end
        mLast  = w[0];
        mRdata = rdata;
        for (int d = 0; d < 2; d++)
            if (mCnt[d][w[d]] < cntMax[d]) mCnt[d][w[d]]++;
        tick();
        memResp  = 1'($urandom);
        memRdata = ~rdata;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("relRead", 64'(memRead[d]), 64'd0);
            checkOutput("relWrite", 64'(memWrite[d]), 64'd0);
            checkOutput("relResp", 64'(upResp[d]), 64'd0);
            checkOutput("relBusy", 64'(busyOut[d]), 64'd1);
            checkOutput("relRdata", upRdata[d], mRdata);
        end
        checkCounts("grantCount");
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("idleBusy", 64'(busyOut[d]), 64'd0);
            checkOutput("idleRdata", upRdata[d], mRdata);
        end
        memResp = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        upRead    = '0;
        upWrite   = '0;
        upAddress = '0;
        upWdata   = '0;
        memRdata  = '0;
        memResp   = 1'b0;
        applyReset();

        // Single read from port 1
        upRead  = 4'b0010;
        upWrite = 4'b0000;
        randomizeData();
        upAddress[32 +: 32] = 32'h0000_0040;
        applyStimulus(4, 64'hDEAD_0123_4567_BEEF);

        // Reset abandons a transaction in its second BUSY cycle
        applyReset();
        upRead  = 4'b0001;
        upWrite = 4'b0000;
        tick();
        tick();
        reset_n = 1'b0;
        memResp = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) checkOutput("rstMidResp", 64'(upResp[d]), 64'd0);
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rstMidRead", 64'(memRead[d]), 64'd0);
            checkOutput("rstMidBusy", 64'(busyOut[d]), 64'd0);
            checkOutput("rstMidResp2", 64'(upResp[d]), 64'd0);
        end
        checkOutput("rstMidRrCnt", 64'(rrCount), 64'd0);
        checkOutput("rstMidFpCnt", 64'(fpCount), 64'd0);
        reset_n = 1'b1;
        memResp = 1'b0;
        upRead  = '0;
        mLast   = 3;
        mRdata  = '0;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 4; p++) mCnt[d][p] = 0;
        tick();

        // All ports contend continuously
        for (int i = 0; i < 8; i++) begin
            upRead  = 4'hF;
            upWrite = 4'h0;
            randomizeData();
            applyStimulus($urandom_range(0, 3), {$urandom, $urandom});
        end
        for (int p = 0; p < 4; p++) checkOutput("rrEven", 64'(rrCount[p*2 +: 2]), 64'd2);
        checkOutput("fpAllPort0", 64'(fpCount[7:0]), 64'd8);

        // Ports 0 and 2 hold, then port 0 drops
        for (int i = 0; i < 4; i++) begin
            upRead  = (i < 3) ? 4'b0101 : 4'b0100;
            upWrite = 4'b0000;
            randomizeData();
            applyStimulus($urandom_range(0, 2), {$urandom, $urandom});
        end

        // Random traffic including idle gaps and simultaneous read+write
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                upRead  = '0;
                upWrite = '0;
                tick();
                for (int d = 0; d < 2; d++) checkOutput("noReqIdle", 64'(busyOut[d]), 64'd0);
            end
            upRead  = 4'($urandom);
            upWrite = 4'($urandom);
            if ((upRead | upWrite) == 4'b0000) upWrite = 4'b1000;
            randomizeData();
            applyStimulus($urandom_range(0, 4), {$urandom, $urandom});
        end

        // Counter saturation on port 0
        applyReset();
        for (int i = 0; i < 5; i++) begin
            upRead  = 4'b0001;
            upWrite = 4'b0000;
            randomizeData();
            applyStimulus(1, {$urandom, $urandom});
        end
        checkOutput("satRr", 64'(rrCount[1:0]), 64'd3);
        checkOutput("satFp", 64'(fpCount[7:0]), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
